// File: rtl/player_cmd_scheduler.sv
// Serializes front-panel button presses and end-of-song into one command stream:
// sticky pending bits, opposite-request cancellation, priority grant, post-command hold-off.
module player_cmd_scheduler #(
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next_song,
    input  logic       prev_song,
    input  logic       play_pause,
    input  logic       pass_30s,
    input  logic       back_30s,
    input  logic       pass_10s,
    input  logic       back_10s,
    input  logic       end_of_song,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       busy,
    output logic [6:0] pending,
    output logic       dropped
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    localparam int unsigned CW   = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int unsigned LOAD = (HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1;
    localparam int unsigned NP   = 3;
    localparam logic [6:0]  SEEK_MASK = 7'b111_1000;

    state_t        state_q, state_d;
    logic [7:0]    in_q, in_d, rise;
    logic [6:0]    pending_q, pending_d;
    logic [6:0]    after_grant, resolved;
    logic [2:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          dropped_q, dropped_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant;
    logic [2:0]    grant_idx;
    logic          grant_drop;
    logic [NP-1:0] pair_drop;

    // Bit 7 is end_of_song; bits 6..0 match the pending vector layout.
    assign in_d = {end_of_song, back_10s, pass_10s, back_30s, pass_30s,
                   play_pause, prev_song, next_song};
    assign rise = in_d & ~in_q;

    always_comb begin
        grant      = (state_q == S_IDLE) && (|pending_q);
        grant_idx  = 3'd0;
        grant_drop = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_idx = 3'(i);
            end
        end
        after_grant = pending_q;
        if (grant) begin
            after_grant[grant_idx] = 1'b0;
            // A track change makes any queued seek meaningless.
            if (grant_idx <= 3'd1) begin
                grant_drop  = |(pending_q & SEEK_MASK);
                after_grant = after_grant & ~SEEK_MASK;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_pair
            localparam int unsigned A = (gi == 0) ? 0 : ((gi == 1) ? 3 : 5);
            localparam int unsigned B = A + 1;
            logic cancel;
            assign cancel = (rise[A] & (rise[B] | after_grant[B])) |
                            (rise[B] & after_grant[A]);
            assign resolved[A]   = ~cancel & (after_grant[A] | rise[A]);
            assign resolved[B]   = ~cancel & (after_grant[B] | rise[B]);
            assign pair_drop[gi] = cancel;
        end
    endgenerate

    assign resolved[2] = after_grant[2] | rise[2];

    always_comb begin
        pending_d = resolved;
        // End of song forces a next-track request that nothing may cancel.
        if (rise[7]) begin
            pending_d[0] = 1'b1;
            pending_d[1] = 1'b0;
        end
        dropped_d = grant_drop | (|pair_drop);
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_ISSUE;
                    valid_d = 1'b1;
                    code_d  = grant_idx + 3'd1;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    valid_d = 1'b0;
                    code_d  = 3'd0;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = CW'(LOAD);
                    end
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                code_d  = 3'd0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            in_q      <= '1;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_valid = valid_q;
    assign cmd_code  = code_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign dropped   = dropped_q;

endmodule

// File: doc/player_cmd_scheduler.md
# player_cmd_scheduler

Arbitrates the player's front-panel buttons and the end-of-song event into a single serialized command stream for the player datapath (address ASM, song-select ASM, play/pause FSM). It edge-detects every request, holds it as a sticky pending bit, resolves conflicting and superseded requests, and issues one command at a time over a valid/ready handshake. After each accepted command it enforces a hold-off window so the timer and address datapath settle before the next command.

## Interface
- HOLDOFF_CYCLES, 4, idle cycles after each accepted command before the next grant (0 = none)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- next_song  in  1  button level, high while pressed
- prev_song  in  1  button level
- play_pause  in  1  button level
- pass_30s  in  1  button level
- back_30s  in  1  button level
- pass_10s  in  1  button level
- back_10s  in  1  button level
- end_of_song  in  1  from address ASM; level, treated like a button
- cmd_ready  in  1  datapath accepts the current command
- cmd_valid  out  1  command presented
- cmd_code  out  3  1 next, 2 prev, 3 play_pause, 4 pass30, 5 back30, 6 pass10, 7 back10; 0 none
- busy  out  1  high in ISSUE or HOLDOFF
- pending  out  7  pending bits {back10,pass10,back30,pass30,play_pause,prev,next}
- dropped  out  1  one-cycle pulse when a request is cancelled or flushed

## Operation
- Edge detect: rise = in & ~in_q per input; in_q registered every cycle. in_q resets to all ones, so inputs held through reset release do not fire.
- end_of_song rise sets the next pending bit and clears prev pending; it is never cancelled.
- Rise sets the matching pending bit at the same clock edge. A rise on an already-pending bit leaves it at 1 and does not queue a second command.
- Opposite pairs: next/prev, pass30/back30, pass10/back10.
  - Both rise in the same cycle: neither is set; dropped pulses.
  - One rises while the other is pending: both are cleared; dropped pulses.
- Priority, highest first: next, prev, play_pause, pass30, back30, pass10, back10.
- Granting next or prev clears all four seek pending bits at the grant edge. dropped pulses if any of them were set.
- States:
  - IDLE: if any pending bit is set, latch the highest-priority code, clear its bit, and go to ISSUE.
  - ISSUE: cmd_valid=1 and cmd_code is stable. On cmd_valid & cmd_ready, go to HOLDOFF with the counter loaded to HOLDOFF_CYCLES-1, or go to IDLE if HOLDOFF_CYCLES==0.
  - HOLDOFF: the counter decrements each cycle; at 0, go to IDLE.
- Rises in ISSUE or HOLDOFF still set pending bits. A rise in the same cycle as its bit is cleared by a grant leaves the bit set; the new press wins.
- A next/prev flush applied while a seek command sits in ISSUE does not retract that command. Once valid is raised, it is held until ready.

## Timing
- Reset values: cmd_valid 0, cmd_code 0, busy 0, pending 0, dropped 0, state IDLE, counter 0.
- An input high before edge k sets pending at edge k. From IDLE, cmd_valid rises at edge k+1, giving 2-edge latency.
- cmd_valid stays high until the first edge with cmd_ready=1. cmd_code is constant while valid.
- cmd_ready sampled while cmd_valid=0 is ignored.
- With HOLDOFF_CYCLES=N, the earliest next cmd_valid is N+1 edges after the accepting edge. With N=0 it is the edge after acceptance, since IDLE costs one cycle.
- dropped is registered and high for exactly the cycle after the event edge. Simultaneous drop causes produce a single pulse.
- Asserting reset mid-ISSUE drops cmd_valid immediately (async) and discards all pending requests.

## Test plan
- Reset release with pass_30s held high -> no pending, no command. Release, then press again -> cmd_code 4 valid 2 edges after the press.
- pass_10s then next_song pressed before the grant, cmd_ready=1 -> next (code 1) issued first, pass10 flushed, dropped pulses once, no code 6 issued.
- pass_30s and back_30s high in the same cycle -> pending stays 0, dropped pulses, cmd_valid stays 0.
- cmd_ready held 0 for 10 cycles with code 3 valid -> cmd_valid and cmd_code stay constant. Ready at cycle 10 -> busy remains high for 4 more cycles (HOLDOFF_CYCLES=4), then the next pending command issues.
- prev_song pending, end_of_song rises -> prev cleared, code 1 issued, no dropped pulse for end_of_song.
- Same button pressed 3 times during HOLDOFF -> exactly one command issued after hold-off.
